// File: rtl/axi_burst_mem_slave_pkg.sv
// Shared AXI types for the burst memory slave: burst and response
// encodings, channel FSM states and a response-severity merge helper.
package axi_burst_mem_slave_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1,
    WRAP  = 2'd2,
    RSVD  = 2'd3
  } axi_burst_e;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } axi_resp_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_e;

  // Encodings are already ordered by severity (DECERR > SLVERR > OKAY);
  // EXOKAY is never generated by this slave.
  function automatic axi_resp_e resp_max(input axi_resp_e a, input axi_resp_e b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Per-channel AXI burst word-address generator.
//   clk_i/rst_i : clock, async active-high reset
//   load_i      : capture start_i/len_i/burst_i for a new burst
//   advance_i   : step to the next beat (may coincide with load_i)
//   idx_o       : word index of the current beat
//   beat_o      : current beat number (0-based)
//   last_o      : current beat is beat len+1
//   err_o       : burst type/len combination is illegal (SLVERR per beat)
module axi_burst_addr_gen
  import axi_burst_mem_slave_pkg::*;
#(
  parameter int unsigned IDX_W = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [IDX_W-1:0] start_i,
  input  logic [7:0]       len_i,
  input  axi_burst_e       burst_i,
  input  logic             advance_i,
  output logic [IDX_W-1:0] idx_o,
  output logic [7:0]       beat_o,
  output logic             last_o,
  output logic             err_o
);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       len_q, len_d;
  axi_burst_e       burst_q, burst_d;

  logic [IDX_W-1:0] cur_idx, inc_idx, wrap_mask, next_idx;
  logic [7:0]       cur_cnt, cur_len;
  axi_burst_e       cur_burst, eff_burst;
  logic             wrap_len_ok;

  // On load the new burst parameters are bypassed straight to the outputs,
  // so the first beat can be consumed in the same cycle as the address
  // handshake.
  always_comb begin
    cur_idx   = load_i ? start_i : idx_q;
    cur_cnt   = load_i ? 8'd0    : cnt_q;
    cur_len   = load_i ? len_i   : len_q;
    cur_burst = load_i ? burst_i : burst_q;

    wrap_len_ok = (cur_len == 8'd1) || (cur_len == 8'd3) ||
                  (cur_len == 8'd7) || (cur_len == 8'd15);

    err_o     = 1'b0;
    eff_burst = cur_burst;
    if (cur_burst == RSVD) begin
      err_o     = 1'b1;
      eff_burst = FIXED;
    end else if ((cur_burst == WRAP) && !wrap_len_ok) begin
      err_o     = 1'b1;
      eff_burst = INCR;
    end

    inc_idx   = cur_idx + IDX_W'(1);
    wrap_mask = IDX_W'(cur_len);
    case (eff_burst)
      FIXED:   next_idx = cur_idx;
      WRAP:    next_idx = (cur_idx & ~wrap_mask) | (inc_idx & wrap_mask);
      default: next_idx = inc_idx;
    endcase

    idx_o  = cur_idx;
    beat_o = cur_cnt;
    last_o = (cur_cnt == cur_len);

    idx_d   = idx_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    burst_d = burst_q;
    if (load_i || advance_i) begin
      idx_d   = advance_i ? next_idx : cur_idx;
      cnt_d   = advance_i ? (cur_cnt + 8'd1) : cur_cnt;
      len_d   = cur_len;
      burst_d = cur_burst;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      burst_q <= FIXED;
    end else begin
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      burst_q <= burst_d;
    end
  end

endmodule

// File: rtl/axi_burst_mem_slave.sv
// AXI4 burst memory slave backed by a DEPTH x DATA_WIDTH register array.
// Independent write (AW/W/B) and read (AR/R) FSMs, one beat per cycle each.
// Ports: s00_axi_aclk/s00_axi_areset (async active-high), full AXI4
// AW/W/B/AR/R channels without size/prot/cache signals.
module axi_burst_mem_slave
  import axi_burst_mem_slave_pkg::*;
#(
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DEPTH      = 256
) (
  input  logic                    s00_axi_aclk,
  input  logic                    s00_axi_areset,
  input  logic [ID_WIDTH-1:0]     s00_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [7:0]              s00_axi_awlen,
  input  logic [1:0]              s00_axi_awburst,
  input  logic                    s00_axi_awvalid,
  output logic                    s00_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                    s00_axi_wlast,
  input  logic                    s00_axi_wvalid,
  output logic                    s00_axi_wready,
  output logic [ID_WIDTH-1:0]     s00_axi_bid,
  output logic [1:0]              s00_axi_bresp,
  output logic                    s00_axi_bvalid,
  input  logic                    s00_axi_bready,
  input  logic [ID_WIDTH-1:0]     s00_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [7:0]              s00_axi_arlen,
  input  logic [1:0]              s00_axi_arburst,
  input  logic                    s00_axi_arvalid,
  output logic                    s00_axi_arready,
  output logic [ID_WIDTH-1:0]     s00_axi_rid,
  output logic [DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]              s00_axi_rresp,
  output logic                    s00_axi_rlast,
  output logic                    s00_axi_rvalid,
  input  logic                    s00_axi_rready
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned OFFS   = $clog2(STRB_W);
  localparam int unsigned IDX_W  = ADDR_WIDTH - OFFS;
  localparam int unsigned MEM_AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Holds both ready outputs low for the first cycle out of reset.
  logic init_q;

  // ---------------- write channel ----------------
  wr_state_e             wr_state_q, wr_state_d;
  logic [ID_WIDTH-1:0]   wid_q, wid_d;
  axi_resp_e             wresp_q, wresp_d, wr_beat_resp;
  logic                  wr_load, wr_adv, wr_en, wr_in_range;
  logic [IDX_W-1:0]      wr_idx;
  logic [7:0]            wr_beat;
  logic                  wr_last, wr_err;

  axi_burst_addr_gen #(.IDX_W(IDX_W)) u_wr_gen (
    .clk_i     (s00_axi_aclk),
    .rst_i     (s00_axi_areset),
    .load_i    (wr_load),
    .start_i   (s00_axi_awaddr[ADDR_WIDTH-1:OFFS]),
    .len_i     (s00_axi_awlen),
    .burst_i   (axi_burst_e'(s00_axi_awburst)),
    .advance_i (wr_adv),
    .idx_o     (wr_idx),
    .beat_o    (wr_beat),
    .last_o    (wr_last),
    .err_o     (wr_err)
  );

  assign wr_in_range = ({1'b0, wr_idx} < (IDX_W+1)'(DEPTH));

  always_comb begin
    wr_state_d      = wr_state_q;
    wid_d           = wid_q;
    wresp_d         = wresp_q;
    wr_load         = 1'b0;
    wr_adv          = 1'b0;
    wr_en           = 1'b0;
    s00_axi_awready = 1'b0;
    s00_axi_wready  = 1'b0;
    s00_axi_bvalid  = 1'b0;

    wr_beat_resp = OKAY;
    if (wr_err || (s00_axi_wlast != wr_last)) wr_beat_resp = SLVERR;
    if (!wr_in_range)                         wr_beat_resp = DECERR;

    case (wr_state_q)
      W_IDLE: begin
        s00_axi_awready = init_q;
        if (s00_axi_awvalid && init_q) begin
          wr_load    = 1'b1;
          wid_d      = s00_axi_awid;
          wresp_d    = OKAY;
          wr_state_d = W_DATA;
        end
      end
      W_DATA: begin
        s00_axi_wready = 1'b1;
        if (s00_axi_wvalid) begin
          wr_adv  = 1'b1;
          wr_en   = wr_in_range;
          wresp_d = resp_max(wresp_q, wr_beat_resp);
          if (wr_last) wr_state_d = W_RESP;
        end
      end
      W_RESP: begin
        s00_axi_bvalid = 1'b1;
        if (s00_axi_bready) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  assign s00_axi_bid   = wid_q;
  assign s00_axi_bresp = (wr_state_q == W_RESP) ? wresp_q : OKAY;

  always_ff @(posedge s00_axi_aclk) begin
    if (wr_en) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (s00_axi_wstrb[b]) mem_q[wr_idx[MEM_AW-1:0]][b*8 +: 8] <= s00_axi_wdata[b*8 +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  rd_state_e             rd_state_q, rd_state_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  axi_resp_e             rresp_q, rresp_d, rd_beat_resp;
  logic                  rlast_q, rlast_d, rvalid_q, rvalid_d;
  logic                  rd_load, rd_adv, rd_in_range;
  logic [IDX_W-1:0]      rd_idx;
  logic [7:0]            rd_beat;
  logic                  rd_last, rd_err;

  axi_burst_addr_gen #(.IDX_W(IDX_W)) u_rd_gen (
    .clk_i     (s00_axi_aclk),
    .rst_i     (s00_axi_areset),
    .load_i    (rd_load),
    .start_i   (s00_axi_araddr[ADDR_WIDTH-1:OFFS]),
    .len_i     (s00_axi_arlen),
    .burst_i   (axi_burst_e'(s00_axi_arburst)),
    .advance_i (rd_adv),
    .idx_o     (rd_idx),
    .beat_o    (rd_beat),
    .last_o    (rd_last),
    .err_o     (rd_err)
  );

  assign rd_in_range = ({1'b0, rd_idx} < (IDX_W+1)'(DEPTH));

  always_comb begin
    rd_beat_resp = OKAY;
    if (rd_err)       rd_beat_resp = SLVERR;
    if (!rd_in_range) rd_beat_resp = DECERR;
  end

  // The generator always points at the next beat to place in the output
  // register; the first beat is fetched on the AR handshake itself (load and
  // advance together) so rvalid rises the following cycle.
  always_comb begin
    rd_state_d      = rd_state_q;
    rid_d           = rid_q;
    rdata_d         = rdata_q;
    rresp_d         = rresp_q;
    rlast_d         = rlast_q;
    rvalid_d        = rvalid_q;
    rd_load         = 1'b0;
    rd_adv          = 1'b0;
    s00_axi_arready = 1'b0;

    case (rd_state_q)
      R_IDLE: begin
        s00_axi_arready = init_q;
        if (s00_axi_arvalid && init_q) begin
          rd_load    = 1'b1;
          rd_adv     = 1'b1;
          rid_d      = s00_axi_arid;
          rd_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (s00_axi_rready) begin
          if (rlast_q) begin
            rvalid_d   = 1'b0;
            rlast_d    = 1'b0;
            rd_state_d = R_IDLE;
          end else begin
            rd_adv = 1'b1;
          end
        end
      end
      default: rd_state_d = R_IDLE;
    endcase

    if (rd_adv) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_in_range ? mem_q[rd_idx[MEM_AW-1:0]] : '0;
      rresp_d  = rd_beat_resp;
      rlast_d  = rd_last;
    end
  end

  assign s00_axi_rid    = rid_q;
  assign s00_axi_rdata  = rdata_q;
  assign s00_axi_rresp  = rresp_q;
  assign s00_axi_rlast  = rlast_q;
  assign s00_axi_rvalid = rvalid_q;

  // ---------------- state registers ----------------
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      init_q     <= 1'b0;
      wr_state_q <= W_IDLE;
      wid_q      <= '0;
      wresp_q    <= OKAY;
      rd_state_q <= R_IDLE;
      rid_q      <= '0;
      rdata_q    <= '0;
      rresp_q    <= OKAY;
      rlast_q    <= 1'b0;
      rvalid_q   <= 1'b0;
    end else begin
      init_q     <= 1'b1;
      wr_state_q <= wr_state_d;
      wid_q      <= wid_d;
      wresp_q    <= wresp_d;
      rd_state_q <= rd_state_d;
      rid_q      <= rid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      rlast_q    <= rlast_d;
      rvalid_q   <= rvalid_d;
    end
  end

  // Byte-offset address bits and beat counters are not needed here.
  logic unused_bits;
  assign unused_bits = ^{s00_axi_awaddr[OFFS-1:0], s00_axi_araddr[OFFS-1:0], wr_beat, rd_beat};

endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// Scoreboard bench for axi_burst_mem_slave: stimulus tasks push expected
// B/R responses into queues, a negedge monitor pops and compares on each
// handshake and checks R stability while stalled.
module tb_axi_burst_mem_slave;
  import axi_burst_mem_slave_pkg::*;

  localparam int IDW = 1;
  localparam int DW  = 512;
  localparam int AW  = 16;
  localparam int DEP = 256;
  localparam int SW  = DW / 8;
  localparam int CW  = DW + 8;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [IDW-1:0] awid = '0, arid = '0, bid, rid;
  logic [AW-1:0]  awaddr = '0, araddr = '0;
  logic [7:0]     awlen = '0, arlen = '0;
  logic [1:0]     awburst = '0, arburst = '0, bresp, rresp;
  logic           awvalid = 1'b0, awready, wlast = 1'b0, wvalid = 1'b0, wready;
  logic           bvalid, bready = 1'b1, arvalid = 1'b0, arready;
  logic           rlast, rvalid, rready = 1'b1;
  logic [DW-1:0]  wdata = '0, rdata;
  logic [SW-1:0]  wstrb = '0;

  always #5 clk = ~clk;

  axi_burst_mem_slave #(
    .ID_WIDTH(IDW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEP)
  ) dut (
    .s00_axi_aclk(clk), .s00_axi_areset(rst),
    .s00_axi_awid(awid), .s00_axi_awaddr(awaddr), .s00_axi_awlen(awlen),
    .s00_axi_awburst(awburst), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wlast(wlast),
    .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bid(bid), .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_arid(arid), .s00_axi_araddr(araddr), .s00_axi_arlen(arlen),
    .s00_axi_arburst(arburst), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rid(rid), .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rlast(rlast),
    .s00_axi_rvalid(rvalid), .s00_axi_rready(rready)
  );

  typedef struct { logic [IDW-1:0] id; logic [DW-1:0] data; logic [1:0] resp; logic last; } r_exp_t;
  typedef struct { logic [IDW-1:0] id; logic [1:0] resp; } b_exp_t;

  r_exp_t      rq[$];
  b_exp_t      bq[$];
  r_exp_t      re;
  b_exp_t      be;
  int unsigned n_pass = 0, n_total = 0, r_beats = 0;
  logic        stall_prev = 1'b0;
  logic [CW-1:0] stall_snap = '0;

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    n_total++;
    $display("FAIL %s: got no handshake expected one within the cycle budget", name);
  endtask

  function automatic logic [DW-1:0] mk(input logic [7:0] tag, input logic [7:0] k);
    logic [DW-1:0] v;
    for (int j = 0; j < DW / 32; j++) v[j*32 +: 32] = {tag, k, 16'(j)};
    return v;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        check("r_stall_hold", CW'({rvalid, rlast, rresp, rid, rdata}), stall_snap);
      stall_prev = rvalid && !rready;
      stall_snap = CW'({rvalid, rlast, rresp, rid, rdata});
      if (bvalid && bready) begin
        if (bq.size() == 0) begin
          n_total++;
          $display("FAIL b_unexpected: got bid %0h bresp %0d expected no response", bid, bresp);
        end else begin
          be = bq.pop_front();
          check("bid", CW'(bid), CW'(be.id));
          check("bresp", CW'(bresp), CW'(be.resp));
        end
      end
      if (rvalid && rready) begin
        r_beats++;
        if (rq.size() == 0) begin
          n_total++;
          $display("FAIL r_unexpected: got rdata %0h expected no beat", rdata);
        end else begin
          re = rq.pop_front();
          check("rid", CW'(rid), CW'(re.id));
          check("rdata", CW'(rdata), CW'(re.data));
          check("rresp", CW'(rresp), CW'(re.resp));
          check("rlast", CW'(rlast), CW'(re.last));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic aw_send(input logic [IDW-1:0] id, input logic [AW-1:0] a,
                         input logic [7:0] len, input logic [1:0] bt);
    int unsigned n = 0;
    awid = id; awaddr = a; awlen = len; awburst = bt; awvalid = 1'b1;
    @(negedge clk);
    while (!awready && n < 50) begin @(negedge clk); n++; end
    if (!awready) timeout("aw_handshake");
    @(posedge clk); #1 awvalid = 1'b0;
  endtask

  task automatic ar_send(input logic [IDW-1:0] id, input logic [AW-1:0] a,
                         input logic [7:0] len, input logic [1:0] bt);
    int unsigned n = 0;
    arid = id; araddr = a; arlen = len; arburst = bt; arvalid = 1'b1;
    @(negedge clk);
    while (!arready && n < 50) begin @(negedge clk); n++; end
    if (!arready) timeout("ar_handshake");
    @(posedge clk); #1 arvalid = 1'b0;
  endtask

  task automatic w_send(input logic [DW-1:0] d, input logic [SW-1:0] s, input logic l);
    int unsigned n = 0;
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
    @(negedge clk);
    while (!wready && n < 50) begin @(negedge clk); n++; end
    if (!wready) timeout("w_handshake");
    @(posedge clk); #1 wvalid = 1'b0;
  endtask

  task automatic wr_burst(input logic [IDW-1:0] id, input logic [AW-1:0] a, input logic [7:0] len,
                          input logic [1:0] bt, input logic [7:0] tag, input logic [1:0] resp);
    bq.push_back('{id: id, resp: resp});
    aw_send(id, a, len, bt);
    for (int k = 0; k <= int'(len); k++) w_send(mk(tag, 8'(k)), '1, k == int'(len));
  endtask

  task automatic push_r(input logic [IDW-1:0] id, input logic [DW-1:0] d,
                        input logic [1:0] resp, input logic last);
    rq.push_back('{id: id, data: d, resp: resp, last: last});
  endtask

  task automatic drain();
    int unsigned n = 0;
    while ((rq.size() != 0 || bq.size() != 0) && n < 200) begin tick(); n++; end
    if (rq.size() != 0 || bq.size() != 0) timeout("drain");
  endtask

  task automatic chk_zero(input string name);
    check(name, CW'({awready, wready, bvalid, bid, bresp, arready, rvalid, rid, rresp, rlast}), '0);
    check({name, "_rdata"}, CW'(rdata), '0);
  endtask

  logic [3:0] pat = 4'b1001;

  // ---------------- directed sequence ----------------
  initial begin
    int unsigned base, c;
    #2 rst = 1'b1;
    #1 chk_zero("reset_outputs");
    tick(); tick();
    check("reset_awready_low", CW'(awready), '0);
    @(negedge clk); rst = 1'b0;
    tick();
    check("awready_after_reset", CW'({awready, arready}), CW'(2'b11));

    // INCR write words 1..4, INCR read back
    wr_burst(1'b1, 16'h0040, 8'd3, INCR, 8'h10, OKAY);
    for (int k = 0; k < 4; k++) push_r(1'b0, mk(8'h10, 8'(k)), OKAY, k == 3);
    ar_send(1'b0, 16'h0040, 8'd3, INCR);
    drain();

    // preload words 0..3, WRAP read from word 3 -> 3,0,1,2
    wr_burst(1'b0, 16'h0000, 8'd3, INCR, 8'h30, OKAY);
    push_r(1'b1, mk(8'h30, 8'd3), OKAY, 1'b0);
    push_r(1'b1, mk(8'h30, 8'd0), OKAY, 1'b0);
    push_r(1'b1, mk(8'h30, 8'd1), OKAY, 1'b0);
    push_r(1'b1, mk(8'h30, 8'd2), OKAY, 1'b1);
    ar_send(1'b1, 16'h00C0, 8'd3, WRAP);
    drain();

    // reserved burst type behaves as FIXED with SLVERR each beat
    push_r(1'b0, mk(8'h30, 8'd1), SLVERR, 1'b0);
    push_r(1'b0, mk(8'h30, 8'd1), SLVERR, 1'b1);
    ar_send(1'b0, 16'h0040, 8'd1, RSVD);
    drain();

    // WRAP with illegal len 2: SLVERR, treated as INCR (words 1,2,3)
    for (int k = 1; k < 4; k++) push_r(1'b0, mk(8'h30, 8'(k)), SLVERR, k == 3);
    ar_send(1'b0, 16'h0040, 8'd2, WRAP);
    drain();

    // byte strobes on word 5
    bq.push_back('{id: 1'b0, resp: OKAY});
    aw_send(1'b0, 16'h0140, 8'd0, INCR);
    w_send('1, '1, 1'b1);
    bq.push_back('{id: 1'b0, resp: OKAY});
    aw_send(1'b0, 16'h0140, 8'd0, INCR);
    w_send('0, SW'(4'hF), 1'b1);
    push_r(1'b0, {{(DW-32){1'b1}}, 32'h0}, OKAY, 1'b1);
    ar_send(1'b0, 16'h0140, 8'd0, INCR);
    drain();

    // missing wlast on the only beat -> SLVERR
    bq.push_back('{id: 1'b1, resp: SLVERR});
    aw_send(1'b1, 16'h0180, 8'd0, INCR);
    w_send(mk(8'h50, 8'd0), '1, 1'b0);
    drain();

    // end of memory: word 255 written, word 256 dropped
    wr_burst(1'b0, 16'h3FC0, 8'd1, INCR, 8'h40, DECERR);
    push_r(1'b0, mk(8'h40, 8'd0), OKAY, 1'b1);
    ar_send(1'b0, 16'h3FC0, 8'd0, INCR);
    push_r(1'b1, '0, DECERR, 1'b1);
    ar_send(1'b1, 16'h4000, 8'd0, INCR);
    drain();

    // stalled len-7 read concurrent with a write burst
    wr_burst(1'b0, 16'h0200, 8'd7, INCR, 8'h60, OKAY);
    drain();
    fork
      begin
        for (int k = 0; k < 8; k++) push_r(1'b1, mk(8'h60, 8'(k)), OKAY, k == 7);
        base = r_beats;
        ar_send(1'b1, 16'h0200, 8'd7, INCR);
        c = 0;
        while (r_beats < base + 8 && c < 200) begin
          rready = pat[c % 4];
          tick();
          c++;
        end
        rready = 1'b1;
        if (r_beats < base + 8) timeout("stalled_read");
      end
      begin
        wr_burst(1'b1, 16'h0500, 8'd3, INCR, 8'h61, OKAY);
      end
    join
    drain();
    for (int k = 0; k < 4; k++) push_r(1'b0, mk(8'h61, 8'(k)), OKAY, k == 3);
    ar_send(1'b0, 16'h0500, 8'd3, INCR);
    drain();

    // reset in the middle of a len-7 write: no response, outputs cleared
    aw_send(1'b1, 16'h0600, 8'd7, INCR);
    w_send(mk(8'h70, 8'd0), '1, 1'b0);
    w_send(mk(8'h70, 8'd1), '1, 1'b0);
    wdata = mk(8'h70, 8'd2); wstrb = '1; wlast = 1'b0; wvalid = 1'b1;
    @(negedge clk); #2 rst = 1'b1;
    #1 chk_zero("midburst_reset_outputs");
    tick();
    check("midburst_reset_bvalid", CW'(bvalid), '0);
    wvalid = 1'b0;
    @(negedge clk); rst = 1'b0;
    tick();
    check("awready_after_midburst_reset", CW'({awready, bvalid}), CW'(2'b10));
    wr_burst(1'b0, 16'h0600, 8'd1, INCR, 8'h71, OKAY);
    for (int k = 0; k < 2; k++) push_r(1'b0, mk(8'h71, 8'(k)), OKAY, k == 1);
    ar_send(1'b0, 16'h0600, 8'd1, INCR);
    drain();

    tick();
    check("scoreboard_empty", CW'(rq.size() + bq.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
